regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file with a write-back scoreboard, for the pipelined core.
//  Provides NRD combinational read ports and one write-back port with same-cycle write-to-read bypass.
//  Holds a busy bit per register: set when an instruction claims a destination at issue, cleared at write-back.
//  Sits between the decode/issue stage (reads, claims) and the write-back stage.
// PARAMETERS
//  XLEN   32  data width of each register
//  NREGS  32  number of architectural registers; power of two, >= 2; AW = $clog2(NREGS)
//  NRD    2   number of read ports, 1..4
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  rst_n      in   1         synchronous reset, active low
//  rd_addr    in   NRD x AW  read addresses
//  rd_data    out  NRD x XLEN read data, bypassed
//  rd_busy    out  NRD       source register has an outstanding write
//  iss_valid  in   1         issue stage claims destination iss_rd
//  iss_rd     in   AW        destination register to mark busy
//  iss_ready  out  1         claim accepted this cycle
//  wb_valid   in   1         write-back valid
//  wb_addr    in   AW        write-back destination
//  wb_data    in   XLEN      write-back data
//  pend_cnt   out  AW+1      number of registers currently busy
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all registers <= 0, all busy bits <= 0. After reset: rd_data=0, rd_busy=0, pend_cnt=0, iss_ready=1.
//  - Register 0: reads 0 always, never written, never busy. Writes and claims to it are accepted and ignored.
//  - Read: combinational. If wb_valid && wb_addr==rd_addr[i] && rd_addr[i]!=0, then rd_data[i]=wb_data (bypass).
//    Otherwise rd_data[i] is the array value.
//  - rd_busy[i]: busy[rd_addr[i]] && !(wb_valid && wb_addr==rd_addr[i]). Bypass clears the hazard in the same cycle.
//  - Write: wb_valid=1 writes wb_data to wb_addr at the edge. The array is readable from the next cycle; the bypass covers the same cycle.
//    Write-back to a non-busy register is legal; it writes data and leaves busy unchanged.
//  - Claim handshake: iss_ready = !(busy[iss_rd] && !(wb_valid && wb_addr==iss_rd)). This blocks WAW. The combinational ready has no registered state.
//    A claim occurs when iss_valid && iss_ready && iss_rd!=0; it sets busy[iss_rd] at the edge.
//  - Simultaneous claim and write-back to the same register: data is written and busy ends SET, because the new claim wins.
//  - Claim and write-back to different registers in the same cycle: both take effect independently.
//  - pend_cnt: registered popcount of busy, updated at the same edge as the busy bits. Range 0..NREGS-1.
//  - Reset mid-operation: all outstanding claims are discarded. Later write-backs to those registers write data only.
//  - Latency: read 0 cycles; write-to-array 1 cycle; claim-to-rd_busy 1 cycle.
// CONFIGURATION
//  REGFILE_SB_DEBUG_EN defined:
//    - adds output dbg_regs [NREGS] x XLEN, the full register array. Entry 0 reads 0.
//    - adds output dbg_busy NREGS, the raw busy vector.
//    - both are combinational views of state, with no bypass.
//  REGFILE_SB_DEBUG_EN undefined: these ports do not exist; functional behaviour is identical.
// STRUCTURE
//  - Package regfile_pkg holds:
//    - XLEN_DEF=32, NREGS_DEF=32;
//    - typedef logic [XLEN_DEF-1:0] word_t;
//    - typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
//    - localparam reg_idx_t ZERO_REG = '0.
//  - Sub-module regfile_scoreboard owns:
//    - the NREGS busy bits, the claim/clear priority, iss_ready and pend_cnt;
//    - ports clk, rst_n, set_v/set_idx, clr_v/clr_idx, query idx -> busy.
//    The top level owns the data array, the bypass muxes and the debug ports.
// TESTING
//  1. Reset, then read x0..x31 on every port -> rd_data=0, rd_busy=0, pend_cnt=0, iss_ready=1.
//  2. wb x5=0xDEADBEEF with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle and every later cycle.
//     wb x0=0x1234 -> x0 reads 0.
//  3. Claim x7 -> next cycle rd_busy=1 for x7, pend_cnt=1, iss_ready=0 for iss_rd=7.
//     wb x7=0x55 -> same cycle rd_busy=0, rd_data=0x55, iss_ready=1. Next cycle pend_cnt=0.
//  4. Busy x9; claim x9 and wb x9=0xA5 in the same cycle -> x9 reads 0xA5, busy stays 1, pend_cnt stays 1.
//  5. Claim x3, x4 and x6 -> pend_cnt=3. Assert rst_n=0 for one cycle -> all busy=0, pend_cnt=0, x3 reads 0.
//  6. With REGFILE_SB_DEBUG_EN defined: wb x31=0xFFFFFFFF -> next cycle dbg_regs[31]=0xFFFFFFFF, dbg_busy=0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_pkg: shared defaults and types for the register file / scoreboard slice.
//   XLEN_DEF, NREGS_DEF : default data width and register count
//   word_t, reg_idx_t   : data word and register index at default sizing
//   ZERO_REG            : hard-wired zero register index
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0]          word_t;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/issue and write-back connection to the register file.
//   rd_addr/rd_data/rd_busy       : NRD combinational read ports with hazard flag
//   iss_valid/iss_rd/iss_ready    : destination claim handshake
//   wb_valid/wb_addr/wb_data      : write-back port
//   pend_cnt                      : number of registers currently busy
// master = pipeline side, slave = register file.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) ();
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     wb_valid;
  logic [AW-1:0]            wb_addr;
  logic [XLEN-1:0]          wb_data;
  logic [AW:0]              pend_cnt;

  modport master (
    output rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
    input  rd_data, rd_busy, iss_ready, pend_cnt
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, iss_ready, pend_cnt
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits for the write-back scoreboard.
//   clk, rst_n          : clock, synchronous active-low reset
//   set_v/set_idx       : claim request; set_ready says whether it is accepted
//   clr_v/clr_idx       : write-back clearing a busy bit
//   q_idx/q_busy        : NQ hazard queries (a same-cycle clear hides the hazard)
//   cnt                 : registered popcount of the busy bits
//   busy_vec            : raw busy vector (only with REGFILE_SB_DEBUG_EN)
// Register 0 is never marked busy. A claim and a clear to the same register in
// one cycle leave the bit set: the clear is applied first, then the claim.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NQ    = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_v,
  input  logic [AW-1:0]        set_idx,
  output logic                 set_ready,
  input  logic                 clr_v,
  input  logic [AW-1:0]        clr_idx,
  input  logic [NQ-1:0][AW-1:0] q_idx,
  output logic [NQ-1:0]        q_busy,
  output logic [AW:0]          cnt
`ifdef REGFILE_SB_DEBUG_EN
  ,
  output logic [NREGS-1:0]     busy_vec
`endif
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             claim;

`ifdef REGFILE_SB_DEBUG_EN
  assign busy_vec = busy;
`endif

  always_comb begin
    set_ready = !(busy[set_idx] && !(clr_v && clr_idx == set_idx));
    for (int unsigned i = 0; i < NQ; i++) begin
      q_busy[i] = busy[q_idx[i]] && !(clr_v && clr_idx == q_idx[i]);
    end
  end

  assign claim = set_v && set_ready && (set_idx != '0);

  always_comb begin
    busy_nxt = busy;
    if (clr_v) busy_nxt[clr_idx] = 1'b0;
    if (claim) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-back scoreboard.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : regfile_sb_if slave (read ports, claim handshake, write-back, pend_cnt)
//   dbg_regs   : full register array, no bypass   (only with REGFILE_SB_DEBUG_EN)
//   dbg_busy   : raw busy vector                  (only with REGFILE_SB_DEBUG_EN)
// Reads are combinational with write-back bypass; register 0 reads zero and is
// never written. Busy tracking lives in regfile_scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_sb_if.slave      bus
`ifdef REGFILE_SB_DEBUG_EN
  ,
  output logic [XLEN-1:0]  dbg_regs [NREGS],
  output logic [NREGS-1:0] dbg_busy
`endif
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_valid && bus.wb_addr != '0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign bus.rd_data[i] =
      (bus.wb_valid && bus.wb_addr == bus.rd_addr[i] && bus.rd_addr[i] != '0)
        ? bus.wb_data : regs[bus.rd_addr[i]];
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NQ    (NRD)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_v     (bus.iss_valid),
    .set_idx   (bus.iss_rd),
    .set_ready (bus.iss_ready),
    .clr_v     (bus.wb_valid),
    .clr_idx   (bus.wb_addr),
    .q_idx     (bus.rd_addr),
    .q_busy    (bus.rd_busy),
    .cnt       (bus.pend_cnt)
`ifdef REGFILE_SB_DEBUG_EN
    ,
    .busy_vec  (dbg_busy)
`endif
  );

`ifdef REGFILE_SB_DEBUG_EN
  assign dbg_regs = regs;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   chk_en;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

`ifdef REGFILE_SB_DEBUG_EN
  logic [XLEN-1:0]  dbg_regs [NREGS];
  logic [NREGS-1:0] dbg_busy;
`endif

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef REGFILE_SB_DEBUG_EN
    ,
    .dbg_regs (dbg_regs),
    .dbg_busy (dbg_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural values and outstanding claims.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wb_hits(input int a);
    return bus.wb_valid && int'(bus.wb_addr) == a;
  endfunction

  function automatic logic [31:0] exp_data(input int a);
    if (a != 0 && wb_hits(a)) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return m_busy[a] && !wb_hits(a);
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Model state advance, using the inputs held stable across the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 0;
      end
    end else begin
      int  ir;
      int  wa;
      bit  rdy;
      ir  = int'(bus.iss_rd);
      wa  = int'(bus.wb_addr);
      rdy = !exp_busy(ir);
      if (bus.wb_valid && wa != 0) m_regs[wa] = bus.wb_data;
      if (bus.wb_valid) m_busy[wa] = 0;
      if (bus.iss_valid && rdy && ir != 0) m_busy[ir] = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        check("rd_data", 64'(bus.rd_data[i]), 64'(exp_data(int'(bus.rd_addr[i]))));
        check("rd_busy", 64'(bus.rd_busy[i]), 64'(exp_busy(int'(bus.rd_addr[i]))));
      end
      check("iss_ready", 64'(bus.iss_ready), 64'(!exp_busy(int'(bus.iss_rd))));
      check("pend_cnt", 64'(bus.pend_cnt), 64'(model_cnt()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 0;
    rst_n  = 1'b0;
    bus.rd_addr = '0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    chk_en = 1;

    // Reset state on all registers and ports
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr[0] = 5'(a);
      bus.rd_addr[1] = 5'(31 - a);
      #1;
      check("rst_data0", 64'(bus.rd_data[0]), 64'h0);
      check("rst_data1", 64'(bus.rd_data[1]), 64'h0);
      check("rst_busy", 64'(bus.rd_busy), 64'h0);
    end
    check("rst_pend", 64'(bus.pend_cnt), 64'h0);
    check("rst_ready", 64'(bus.iss_ready), 64'h1);

    // Write with same-cycle bypass, then from the array
    bus.rd_addr[0] = 5'd5;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1 check("wb_bypass", 64'(bus.rd_data[0]), 64'hDEADBEEF);
    cyc(); idle();
    #1 check("wb_array", 64'(bus.rd_data[0]), 64'hDEADBEEF);
    cyc();
    check("wb_array2", 64'(bus.rd_data[0]), 64'hDEADBEEF);

    // x0 ignores writes
    bus.rd_addr[0] = 5'd0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
    #1 check("x0_bypass", 64'(bus.rd_data[0]), 64'h0);
    cyc(); idle();
    #1 check("x0_array", 64'(bus.rd_data[0]), 64'h0);

    // Claim x7, then clear it by write-back
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    cyc(); idle();
    bus.rd_addr[0] = 5'd7; bus.iss_rd = 5'd7;
    #1;
    check("claim_busy", 64'(bus.rd_busy[0]), 64'h1);
    check("claim_pend", 64'(bus.pend_cnt), 64'h1);
    check("claim_waw", 64'(bus.iss_ready), 64'h0);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h55;
    #1;
    check("wb7_busy", 64'(bus.rd_busy[0]), 64'h0);
    check("wb7_data", 64'(bus.rd_data[0]), 64'h55);
    check("wb7_ready", 64'(bus.iss_ready), 64'h1);
    cyc(); idle();
    #1 check("wb7_pend", 64'(bus.pend_cnt), 64'h0);

    // Claim and write-back to the same busy register: claim wins
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cyc();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hA5;
    #1 check("x9_ready", 64'(bus.iss_ready), 64'h1);
    cyc(); idle();
    bus.rd_addr[0] = 5'd9;
    #1;
    check("x9_data", 64'(bus.rd_data[0]), 64'hA5);
    check("x9_busy", 64'(bus.rd_busy[0]), 64'h1);
    check("x9_pend", 64'(bus.pend_cnt), 64'h1);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hA5;
    cyc(); idle();

    // Three claims, then reset discards them
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd3; cyc();
    bus.iss_rd = 5'd4; cyc();
    bus.iss_rd = 5'd6; cyc();
    idle();
    #1 check("pend3", 64'(bus.pend_cnt), 64'h3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.rd_addr[0] = 5'd3;
    #1;
    check("rst_mid_pend", 64'(bus.pend_cnt), 64'h0);
    check("rst_mid_busy", 64'(bus.rd_busy[0]), 64'h0);
    check("rst_mid_data", 64'(bus.rd_data[0]), 64'h0);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h77;
    cyc(); idle();
    #1;
    check("post_rst_wb_data", 64'(bus.rd_data[0]), 64'h77);
    check("post_rst_wb_pend", 64'(bus.pend_cnt), 64'h0);

`ifdef REGFILE_SB_DEBUG_EN
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 32'hFFFFFFFF;
    cyc(); idle();
    #1;
    check("dbg_regs31", 64'(dbg_regs[31]), 64'hFFFFFFFF);
    check("dbg_regs0", 64'(dbg_regs[0]), 64'h0);
    check("dbg_busy", 64'(dbg_busy), 64'h0);
`endif

    // Randomized traffic, biased toward a few registers to force collisions
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < NRD; i++)
        bus.rd_addr[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      bus.iss_valid = ($urandom_range(0, 2) != 0);
      bus.iss_rd    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      bus.wb_valid  = ($urandom_range(0, 1) == 1);
      bus.wb_addr   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      bus.wb_data   = $urandom;
      cyc();
    end

    rst_n = 1'b1;
    idle();
    cyc();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
